// File: rtl/lut_table_writer.sv
`default_nettype none
// ============================================================================
// Module   : lut_table_writer
// Brief    : Runtime-loadable LUT neuron. Takes a truth table as config beats
//            and serves registered one-cycle lookups once the table is whole.
// Revision : 1.0
// ============================================================================
module lut_table_writer #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    input  logic                cfg_last,
    output logic                cfg_err,
    output logic                table_valid,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_miss
);

    localparam int DEPTH  = 1 << IN_BITS;
    localparam int FLAT_W = DEPTH * OUT_BITS;
    localparam int NBEATS = FLAT_W / CFG_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBEATS - 1);

    generate
        if ((FLAT_W % CFG_W) != 0) begin : g_param_check
            $error("lut_table_writer: table width must be a multiple of CFG_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           err_q, err_d;
    logic                           wr_en;
    logic [CNT_W-1:0]               wr_idx;
    logic [NBEATS-1:0][CFG_W-1:0]   table_q;
    logic [FLAT_W-1:0]              flat_w;
    logic [OUT_BITS-1:0]            rd_entry;
    logic                           out_valid_q;
    logic [OUT_BITS-1:0]            out_data_q;
    logic                           out_miss_q;

    // The writer never back-pressures.
    assign cfg_ready   = 1'b1;
    assign cfg_err     = err_q;
    assign table_valid = (state_q == ST_READY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        if (cfg_valid) begin
            wr_en = 1'b1;
            if (state_q == ST_LOAD) begin
                wr_idx = cnt_q;
                if (cnt_q == LAST_IDX) begin
                    cnt_d = '0;
                    if (cfg_last) begin
                        state_d = ST_READY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_EMPTY;
                    end
                end else if (cfg_last) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_EMPTY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                // First beat of a load: overwrite entry 0 and clear the error.
                err_d = 1'b0;
                cnt_d = '0;
                if (cfg_last) begin
                    if (NBEATS == 1) begin
                        state_d = ST_READY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_EMPTY;
                    end
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_LOAD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Table storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[wr_idx] <= cfg_data;
        end
    end

    assign flat_w   = table_q;
    assign rd_entry = flat_w[int'(in_data) * OUT_BITS +: OUT_BITS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_miss_q  <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                if (table_valid) begin
                    out_data_q <= rd_entry;
                    out_miss_q <= 1'b0;
                end else begin
                    out_data_q <= '0;
                    out_miss_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_miss  = out_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_table_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_table_writer
// Brief    : Directed plus randomized bench for lut_table_writer against a
//            beat-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_lut_table_writer;

    localparam int IN_BITS  = 6;
    localparam int OUT_BITS = 1;
    localparam int CFG_W    = 8;
    localparam int DEPTH    = 1 << IN_BITS;
    localparam int FLAT_W   = DEPTH * OUT_BITS;
    localparam int NBEATS   = FLAT_W / CFG_W;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [CFG_W-1:0]    cfg_data = '0;
    logic                cfg_last = 1'b0;
    logic                cfg_err;
    logic                table_valid;
    logic                in_valid = 1'b0;
    logic [IN_BITS-1:0]  in_data = '0;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;
    logic                out_miss;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: flat table bits plus the beats of the load in progress.
    bit                  m_bits [FLAT_W];
    logic [CFG_W-1:0]    m_beats [$];
    bit                  m_tv, m_err, m_ov, m_miss;
    logic [OUT_BITS-1:0] m_od;

    lut_table_writer #(
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS),
        .CFG_W   (CFG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .cfg_err    (cfg_err),
        .table_valid(table_valid),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_miss   (out_miss)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        if (!rst) begin
            m_beats.delete();
            m_tv = 0; m_err = 0; m_ov = 0; m_od = '0; m_miss = 0;
            return;
        end
        m_ov = in_valid;
        if (in_valid) begin
            if (m_tv) begin
                for (int b = 0; b < OUT_BITS; b++)
                    m_od[b] = m_bits[int'(in_data) * OUT_BITS + b];
                m_miss = 0;
            end else begin
                m_od = '0;
                m_miss = 1;
            end
        end
        if (cfg_valid) begin
            if (m_beats.size() == 0) begin
                m_err = 0;
                m_tv  = 0;
            end
            for (int b = 0; b < CFG_W; b++)
                m_bits[m_beats.size() * CFG_W + b] = cfg_data[b];
            m_beats.push_back(cfg_data);
            if (cfg_last) begin
                if (m_beats.size() == NBEATS) m_tv = 1;
                else m_err = 1;
                m_beats.delete();
            end else if (m_beats.size() == NBEATS) begin
                m_err = 1;
                m_beats.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: model follows the edge, outputs are compared 1 ns later,
    // then all stimulus returns to idle.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("cfg_ready",   32'(cfg_ready),   32'd1);
        chk("table_valid", 32'(table_valid), 32'(m_tv));
        chk("cfg_err",     32'(cfg_err),     32'(m_err));
        chk("out_valid",   32'(out_valid),   32'(m_ov));
        chk("out_data",    32'(out_data),    32'(m_od));
        chk("out_miss",    32'(out_miss),    32'(m_miss));
        rst = 1'b1; cfg_valid = 1'b0; cfg_last = 1'b0; in_valid = 1'b0;
    endtask

    task automatic beat(input logic [CFG_W-1:0] d, input logic last);
        cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
        cycle();
    endtask

    task automatic lookup(input int a);
        in_valid = 1'b1; in_data = IN_BITS'(a);
        cycle();
    endtask

    task automatic load_table(input logic [CFG_W-1:0] b3);
        for (int k = 0; k < NBEATS; k++)
            beat((k == 3) ? b3 : 8'h00, k == NBEATS - 1);
    endtask

    initial begin
        // 1: reset, then a lookup with no table misses.
        rst = 1'b0;
        cycle();
        lookup(5);
        cycle();
        // 2: single hot beat, lookups spot-checked around it.
        load_table(8'hB0);
        cycle();
        lookup(28); lookup(29); lookup(31); lookup(30);
        lookup(27); lookup(0);  lookup(63);
        cycle();
        // 3: back-to-back full sweep.
        for (int a = 0; a < DEPTH; a++) lookup(a);
        cycle();
        // 4: early last, miss, then a clean reload.
        for (int k = 0; k < 5; k++) beat(8'h5A, k == 4);
        lookup(12);
        load_table(8'h0F);
        lookup(24); lookup(28);
        cycle();
        // 5: reload aborted by reset, then a normal load.
        beat(8'hFF, 1'b0);
        rst = 1'b0;
        cycle();
        lookup(1);
        load_table(8'hC3);
        lookup(24); lookup(25); lookup(26); lookup(31);
        // 6: missing last, ninth beat starts a fresh load.
        for (int k = 0; k < NBEATS; k++) beat(8'hAA, 1'b0);
        lookup(3);
        beat(8'h11, 1'b0);
        for (int k = 1; k < NBEATS; k++) beat(8'(k * 37), k == NBEATS - 1);
        lookup(0); lookup(4);
        // Randomized mix: beats, overlapping lookups, occasional errors and resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) rst = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                cfg_valid = 1'b1;
                cfg_data  = 8'($urandom);
                cfg_last  = ($urandom_range(0, 15) == 0) ? 1'($urandom)
                                                         : (m_beats.size() == NBEATS - 1);
            end
            in_valid = 1'($urandom);
            in_data  = IN_BITS'($urandom);
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lut_table_writer.md
Name: lut_table_writer

Overview:
- Runtime-programmable LUT neuron: accepts a truth table as a stream of config beats and writes it into a 2^IN_BITS x OUT_BITS distributed RAM.
- Once the table is complete, serves registered lookups in place of a hard-coded case-ROM neuron.
- Lets a quantised-net layer be retrained and reloaded without resynthesis.
- Sits between the config bus (writer side) and the layer datapath (reader side).

Parameters:
IN_BITS, 6, neuron fan-in bits; table depth DEPTH = 2^IN_BITS
OUT_BITS, 1, output bits per entry
CFG_W, 8, config beat width; (DEPTH*OUT_BITS) % CFG_W must be 0; NBEATS = DEPTH*OUT_BITS/CFG_W (default 8)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-low reset
cfg_valid  in  1  config beat valid
cfg_ready  out  1  writer can accept a beat
cfg_data  in  CFG_W  config beat payload
cfg_last  in  1  marks final beat of a table
cfg_err  out  1  sticky: last-beat position mismatch in the most recent load
table_valid  out  1  a complete table is loaded
in_valid  in  1  lookup request
in_data  in  IN_BITS  lookup address (neuron inputs)
out_valid  out  1  lookup result valid
out_data  out  OUT_BITS  table entry
out_miss  out  1  lookup issued while table_valid=0

Behaviour:
- Reset (rst=0 at an edge): state EMPTY; beat counter 0; cfg_ready=1, cfg_err=0, table_valid=0, out_valid=0, out_data=0, out_miss=0. RAM contents are not cleared. Reset mid-load abandons the load.
- Flat bit order: entry e occupies flat bits [e*OUT_BITS +: OUT_BITS]. Beat k carries flat bits [k*CFG_W +: CFG_W], and cfg_data[0] is the lowest flat bit.
- Beat transfer happens when cfg_valid & cfg_ready at a rising edge. cfg_ready is 1 in every state; the writer never back-pressures.
- FSM states: EMPTY, LOAD, READY.
  - EMPTY/READY + beat: write beat at counter index 0.
    - If cfg_last=1 and NBEATS==1: go to READY, table_valid=1.
    - Else if cfg_last=1: cfg_err=1, go to EMPTY.
    - Else: counter=1, go to LOAD, table_valid=0 on the next cycle. Starting a new load from READY drops table_valid.
  - First beat of any load clears cfg_err.
  - LOAD + beat with counter c: write beat c.
    - cfg_last=1 and c==NBEATS-1: counter=0, go to READY, table_valid=1 on the next cycle.
    - cfg_last=1 and c<NBEATS-1 (early last): cfg_err=1, go to EMPTY, counter=0.
    - cfg_last=0 and c==NBEATS-1 (missing last): cfg_err=1, go to EMPTY, counter=0. The next beat starts a fresh load.
    - Otherwise counter=c+1.
  - No beat: hold state.
- Lookup latency is exactly 1 cycle, fully pipelined, and accepts one request per cycle.
  - out_valid(t+1) = in_valid(t).
  - If table_valid(t)=1: out_data(t+1) = RAM[in_data(t)], out_miss=0.
  - If table_valid(t)=0: out_data=0, out_miss=1.
  - When in_valid(t)=0: out_data and out_miss hold their previous values; only out_valid drops.
- Simultaneous final-beat write and lookup in the same cycle: the lookup sees table_valid=0 and misses. The first valid lookup is the cycle after table_valid rises.
- Writes and reads never overlap on valid data: a read is only honoured while table_valid=1, and table_valid=0 throughout any load.

Test Plan:
1. Reset then in_valid=1, in_data=5 -> next cycle out_valid=1, out_miss=1, out_data=0; cfg_ready=1, table_valid=0.
2. Load 8 beats, all 0x00 except beat3=0xB0 (last on beat7) -> table_valid=1 the cycle after beat7. Lookups 28,29,31 -> 1; lookups 30,27,0,63 -> 0; each result 1 cycle after its request.
3. Back-to-back lookups 0..63 on consecutive cycles after load 2 -> 64 consecutive out_valid pulses with matching data, no bubbles.
4. Early last on beat 4 -> cfg_err=1, table_valid=0, next lookup misses. A following correct 8-beat load -> cfg_err clears on its first beat, table_valid=1.
5. From READY, start a reload (1 beat), then assert rst=0 for one cycle -> all outputs at reset values, state EMPTY. A full load then works normally.
6. 8 beats with cfg_last never asserted -> cfg_err=1 after beat7, table_valid stays 0. A 9th beat is treated as beat 0 of a new load.
